// File: rtl/requantize_stream_pkg.sv
// ---------------------------------------------------------------------------
// requantize_stream_pkg
// Shared definitions for the requantizing stream block:
//   - rnd_mode_e    : rounding-mode encoding carried with each sample
//   - OVF_CNT_W     : width of the saturating overflow event counter
//   - DEF_FRAC      : default number of fractional bits on either side
//   - ovf_next()    : next-state helper for the overflow counter
// ---------------------------------------------------------------------------
package requantize_stream_pkg;

  typedef enum logic [1:0] {
    RND_TRUNC     = 2'd0,
    RND_FLOOR     = 2'd1,
    RND_HALF_AWAY = 2'd2
  } rnd_mode_e;

  localparam int OVF_CNT_W = 16;
  localparam int DEF_FRAC  = 10;

  localparam logic [OVF_CNT_W-1:0] OVF_ZERO = {OVF_CNT_W{1'b0}};
  localparam logic [OVF_CNT_W-1:0] OVF_ONE  = {{(OVF_CNT_W-1){1'b0}}, 1'b1};
  localparam logic [OVF_CNT_W-1:0] OVF_MAX  = {OVF_CNT_W{1'b1}};

  // Saturating increment with a clear that still counts a coincident event.
  function automatic logic [OVF_CNT_W-1:0] ovf_next(
    input logic [OVF_CNT_W-1:0] cnt,
    input logic                 event_i,
    input logic                 clear_i
  );
    logic [OVF_CNT_W-1:0] res;
    if (clear_i) begin
      res = event_i ? OVF_ONE : OVF_ZERO;
    end else if (event_i && (cnt != OVF_MAX)) begin
      res = cnt + OVF_ONE;
    end else begin
      res = cnt;
    end
    return res;
  endfunction

endpackage

// File: rtl/requant_round.sv
// ---------------------------------------------------------------------------
// requant_round
// Purely combinational fixed-point rescale by 2^S.
//   S >= 0 : exact left shift, result width IN_W+S.
//   S <  0 : divide by 2^-S with the selected rounding, result width IN_W+1
//            (one guard bit so the half-away offset can never wrap).
// Ports:
//   data_i  [IN_W-1:0]  signed input sample
//   mode_i  [1:0]       rounding mode (rnd_mode_e; 3 behaves as truncate)
//   data_o  [OUT_W-1:0] signed rescaled value
// ---------------------------------------------------------------------------
module requant_round
  import requantize_stream_pkg::*;
#(
  parameter int IN_W  = 32,
  parameter int S     = 0,
  parameter int OUT_W = (S >= 0) ? IN_W + S : IN_W + 1
) (
  input  logic signed [IN_W-1:0]  data_i,
  input  logic        [1:0]       mode_i,
  output logic signed [OUT_W-1:0] data_o
);

  if (S >= 0) begin : g_up
    // Rounding mode is irrelevant when nothing is shifted out.
    logic unused_mode_s;
    assign unused_mode_s = ^mode_i;
    assign data_o = OUT_W'(data_i) <<< S;
  end else begin : g_down
    localparam int K = -S;
    localparam logic signed [IN_W:0] HALF = {{IN_W{1'b0}}, 1'b1} << (K - 1);

    logic signed [IN_W:0] xe_s;
    logic signed [IN_W:0] floor_s;
    logic signed [IN_W:0] trunc_s;
    logic signed [IN_W:0] hy_s;
    logic signed [IN_W:0] hfloor_s;
    logic signed [IN_W:0] half_s;
    logic                 rem_nz_s;
    logic                 hrem_nz_s;

    assign xe_s     = {data_i[IN_W-1], data_i};
    assign floor_s  = xe_s >>> K;
    assign rem_nz_s = |data_i[K-1:0];
    // Negative with a non-zero remainder: floor is one below the truncated value.
    assign trunc_s  = floor_s + {{IN_W{1'b0}}, data_i[IN_W-1] & rem_nz_s};

    // Half-away: push magnitude out by half an LSB, then truncate toward zero.
    // hy_s keeps the sign of the input, so ceil is needed only when negative.
    assign hy_s      = data_i[IN_W-1] ? (xe_s - HALF) : (xe_s + HALF);
    assign hfloor_s  = hy_s >>> K;
    assign hrem_nz_s = |hy_s[K-1:0];
    assign half_s    = hfloor_s + {{IN_W{1'b0}}, hy_s[IN_W] & hrem_nz_s};

    // Select the rounding result for this sample.
    always_comb begin
      data_o = trunc_s;
      case (mode_i)
        RND_FLOOR:     data_o = floor_s;
        RND_HALF_AWAY: data_o = half_s;
        RND_TRUNC:     data_o = trunc_s;
        default:       data_o = trunc_s;
      endcase
    end
  end

endmodule

// File: rtl/requantize_stream.sv
// ---------------------------------------------------------------------------
// requantize_stream
// Two-stage valid/ready pipeline converting signed fixed-point samples from
// IN_FRAC to OUT_FRAC fractional bits and narrowing from IN_W to OUT_W bits.
//   Stage 1: rescale/round (requant_round) into a wide register.
//   Stage 2: narrow to OUT_W, register out_data/out_chan, count overflows.
// Build option: define REQUANT_SAT_EN to clamp out-of-range results to the
// OUT_W signed limits; otherwise they wrap to the low OUT_W bits. Overflow
// events are counted in both builds.
// Ports:
//   clock, reset            rising-edge clock, synchronous active-low reset
//   in_valid/in_ready       input handshake; in_data sample, in_chan tag
//   out_valid/out_ready     output handshake; out_data sample, out_chan tag
//   rnd_mode                rounding mode, captured with each accepted sample
//   ovf_count, ovf_clear    saturating overflow counter and its clear
// ---------------------------------------------------------------------------
module requantize_stream
  import requantize_stream_pkg::*;
#(
  parameter int IN_W     = 32,
  parameter int IN_FRAC  = DEF_FRAC,
  parameter int OUT_W    = 32,
  parameter int OUT_FRAC = DEF_FRAC,
  parameter int CH_W     = 2
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [IN_W-1:0]  in_data,
  input  logic        [CH_W-1:0]  in_chan,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [OUT_W-1:0] out_data,
  output logic        [CH_W-1:0]  out_chan,
  input  logic        [1:0]       rnd_mode,
  output logic [OVF_CNT_W-1:0]    ovf_count,
  input  logic                    ovf_clear
);

  localparam int S      = OUT_FRAC - IN_FRAC;
  localparam int WIDE_W = (S >= 0) ? IN_W + S : IN_W + 1;

  // Pipeline state
  logic                    s1_valid_q,  s1_valid_d;
  logic signed [WIDE_W-1:0] s1_data_q,  s1_data_d;
  logic        [CH_W-1:0]  s1_chan_q,   s1_chan_d;
  logic                    out_valid_q, out_valid_d;
  logic signed [OUT_W-1:0] out_data_q,  out_data_d;
  logic        [CH_W-1:0]  out_chan_q,  out_chan_d;
  logic [OVF_CNT_W-1:0]    ovf_count_q, ovf_count_d;

  // Combinational helpers
  logic signed [WIDE_W-1:0] round_s;
  logic signed [OUT_W-1:0]  narrow_s;
  logic                     ovf_s;
  logic                     s2_ready_s;
  logic                     s1_adv_s;
  logic                     ovf_event_s;

  // Rounding is applied at accept time, so the mode is bound to its sample.
  requant_round #(
    .IN_W  (IN_W),
    .S     (S),
    .OUT_W (WIDE_W)
  ) u_round (
    .data_i (in_data),
    .mode_i (rnd_mode),
    .data_o (round_s)
  );

  // Handshake: each stage loads when empty or when its contents leave.
  assign s2_ready_s  = !out_valid_q || out_ready;
  assign s1_adv_s    = s1_valid_q && s2_ready_s;
  assign in_ready    = !s1_valid_q || s1_adv_s;
  assign ovf_event_s = s1_adv_s && ovf_s;

  if (WIDE_W > OUT_W) begin : g_narrow
    logic [WIDE_W-OUT_W:0] top_s;
    assign top_s = s1_data_q[WIDE_W-1:OUT_W-1];
    // In range only when every bit above the OUT_W sign bit copies it.
    assign ovf_s = !((&top_s) || (~|top_s));
`ifdef REQUANT_SAT_EN
    // Clamp out-of-range values to the signed limit on the matching side.
    always_comb begin
      narrow_s = s1_data_q[OUT_W-1:0];
      if (ovf_s) begin
        narrow_s = s1_data_q[WIDE_W-1] ? {1'b1, {(OUT_W-1){1'b0}}}
                                       : {1'b0, {(OUT_W-1){1'b1}}};
      end else begin
        narrow_s = s1_data_q[OUT_W-1:0];
      end
    end
`else
    assign narrow_s = s1_data_q[OUT_W-1:0];
`endif
  end else begin : g_widen
    assign ovf_s    = 1'b0;
    assign narrow_s = OUT_W'(s1_data_q);
  end

  // Stage 1 next state: capture a new sample only when it is offered.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_data_d  = s1_data_q;
    s1_chan_d  = s1_chan_q;
    if (in_ready) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_data_d = round_s;
        s1_chan_d = in_chan;
      end else begin
        s1_data_d = s1_data_q;
        s1_chan_d = s1_chan_q;
      end
    end else begin
      s1_valid_d = s1_valid_q;
    end
  end

  // Stage 2 next state: outputs hold while stalled downstream.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_chan_d  = out_chan_q;
    if (s2_ready_s) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_data_d = narrow_s;
        out_chan_d = s1_chan_q;
      end else begin
        out_data_d = out_data_q;
        out_chan_d = out_chan_q;
      end
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // Overflow counter next state.
  always_comb begin
    ovf_count_d = ovf_next(ovf_count_q, ovf_event_s, ovf_clear);
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      s1_valid_q  <= 1'b0;
      s1_data_q   <= {WIDE_W{1'b0}};
      s1_chan_q   <= {CH_W{1'b0}};
      out_valid_q <= 1'b0;
      out_data_q  <= {OUT_W{1'b0}};
      out_chan_q  <= {CH_W{1'b0}};
      ovf_count_q <= OVF_ZERO;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_data_q   <= s1_data_d;
      s1_chan_q   <= s1_chan_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_chan_q  <= out_chan_d;
      ovf_count_q <= ovf_count_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_chan  = out_chan_q;
  assign ovf_count = ovf_count_q;

endmodule

// File: tb/tb_requantize_stream.sv
// Bench for requantize_stream. Three instances:
//   dut_a: IN_FRAC=0,  OUT_FRAC=10, 32-bit out (scale up)
//   dut_b: IN_FRAC=10, OUT_FRAC=0,  32-bit out (scale down, rounding)
//   dut_c: IN_FRAC=0,  OUT_FRAC=10, 16-bit out (overflow / counter)
// dut_a and dut_b share their input-side signals.
module tb_requantize_stream;

  logic clock;
  logic reset;

  // Shared stimulus for dut_a / dut_b
  logic               in_valid;
  logic signed [31:0] in_data;
  logic        [1:0]  in_chan;
  logic        [1:0]  rnd_mode;
  logic               out_ready;
  logic               ovf_clear;

  logic               a_in_ready, a_out_valid;
  logic signed [31:0] a_out_data;
  logic        [1:0]  a_out_chan;
  logic        [15:0] a_ovf_count;

  logic               b_in_ready, b_out_valid;
  logic signed [31:0] b_out_data;
  logic        [1:0]  b_out_chan;
  logic        [15:0] b_ovf_count;

  logic               c_in_valid, c_in_ready, c_out_valid, c_ovf_clear;
  logic signed [31:0] c_in_data;
  logic signed [15:0] c_out_data;
  logic        [1:0]  c_out_chan;
  logic        [15:0] c_ovf_count;

  requantize_stream #(.IN_W(32), .IN_FRAC(0), .OUT_W(32), .OUT_FRAC(10), .CH_W(2)) dut_a (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(a_in_ready), .in_data(in_data), .in_chan(in_chan),
    .out_valid(a_out_valid), .out_ready(out_ready), .out_data(a_out_data), .out_chan(a_out_chan),
    .rnd_mode(rnd_mode), .ovf_count(a_ovf_count), .ovf_clear(ovf_clear));

  requantize_stream #(.IN_W(32), .IN_FRAC(10), .OUT_W(32), .OUT_FRAC(0), .CH_W(2)) dut_b (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(b_in_ready), .in_data(in_data), .in_chan(in_chan),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_data(b_out_data), .out_chan(b_out_chan),
    .rnd_mode(rnd_mode), .ovf_count(b_ovf_count), .ovf_clear(ovf_clear));

  requantize_stream #(.IN_W(32), .IN_FRAC(0), .OUT_W(16), .OUT_FRAC(10), .CH_W(2)) dut_c (
    .clock(clock), .reset(reset),
    .in_valid(c_in_valid), .in_ready(c_in_ready), .in_data(c_in_data), .in_chan(2'd0),
    .out_valid(c_out_valid), .out_ready(1'b1), .out_data(c_out_data), .out_chan(c_out_chan),
    .rnd_mode(2'd0), .ovf_count(c_ovf_count), .ovf_clear(c_ovf_clear));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [1:0] mode;
    int         din;
    int         exp_a;
    int         exp_b;
  } vec_t;

  vec_t tbl [16];

`ifdef REQUANT_SAT_EN
  localparam int OVF_A = 32'sh7FFFFFFF;
  localparam int EXP_C = 32767;
`else
  localparam int OVF_A = 32'sh80000000;
  localparam int EXP_C = -24576;
`endif

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic int str_din(input int i);
    return i * 1000 - 50000;
  endfunction

  initial begin
    in_valid = 1'b0; in_data = 32'sd0; in_chan = 2'd0; rnd_mode = 2'd0;
    out_ready = 1'b1; ovf_clear = 1'b0;
    c_in_valid = 1'b0; c_in_data = 32'sd0; c_ovf_clear = 1'b0;
    reset = 1'b0;

    tbl[0]  = '{2'd0, 3,        3072,        0};
    tbl[1]  = '{2'd1, -5,       -5120,       -1};
    tbl[2]  = '{2'd2, -5,       -5120,       0};
    tbl[3]  = '{2'd0, -1536,    -1572864,    -1};
    tbl[4]  = '{2'd1, -1536,    -1572864,    -2};
    tbl[5]  = '{2'd2, -1536,    -1572864,    -2};
    tbl[6]  = '{2'd3, -1536,    -1572864,    -1};
    tbl[7]  = '{2'd0, 1536,     1572864,     1};
    tbl[8]  = '{2'd1, 1536,     1572864,     1};
    tbl[9]  = '{2'd2, 1536,     1572864,     2};
    tbl[10] = '{2'd2, -512,     -524288,     -1};
    tbl[11] = '{2'd0, -512,     -524288,     0};
    tbl[12] = '{2'd2, 511,      523264,      0};
    tbl[13] = '{2'd1, -2048,    -2097152,    -2};
    tbl[14] = '{2'd0, 2097152,  OVF_A,       2048};
    tbl[15] = '{2'd0, -2097152, 32'sh80000000, -2048};

    // Reset state
    repeat (3) tick();
    chk("rst_out_valid", a_out_valid, 0);
    chk("rst_out_data", a_out_data, 0);
    chk("rst_out_chan", a_out_chan, 0);
    chk("rst_ovf_count", a_ovf_count, 0);
    reset = 1'b1;
    chk("rst_in_ready", a_in_ready, 1);
    tick();

    // Table: one sample at a time, latency and value checks.
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1;
      in_data  = tbl[i].din;
      in_chan  = 2'(i);
      rnd_mode = tbl[i].mode;
      chk("tbl_in_ready", a_in_ready, 1);
      tick();
      // Inputs change after accept; results must not depend on them.
      in_valid = 1'b0;
      in_data  = 32'h5A5A_A5A5;
      in_chan  = ~2'(i);
      rnd_mode = ~tbl[i].mode;
      chk("tbl_lat_early", a_out_valid, 0);
      tick();
      chk("tbl_lat_valid", a_out_valid, 1);
      chk("tbl_a_data", a_out_data, tbl[i].exp_a);
      chk("tbl_a_chan", a_out_chan, i % 4);
      chk("tbl_b_data", b_out_data, tbl[i].exp_b);
      chk("tbl_b_chan", b_out_chan, i % 4);
      tick();
      chk("tbl_drained", a_out_valid, 0);
    end
    chk("tbl_a_ovf", a_ovf_count, 1);
    chk("tbl_b_ovf", b_ovf_count, 0);

    // Streaming with random backpressure.
    begin
      int sent, rcv;
      logic stalled;
      logic signed [31:0] held_d;
      logic [1:0] held_c;
      sent = 0; rcv = 0; stalled = 1'b0; held_d = 32'sd0; held_c = 2'd0;
      for (int cyc = 0; cyc < 3000 && rcv < 100; cyc++) begin
        if (sent < 100) begin
          in_valid = 1'b1;
          in_data  = str_din(sent);
          in_chan  = sent[1:0];
          rnd_mode = 2'($urandom_range(0, 3));
        end else begin
          in_valid = 1'b0;
          in_data  = $urandom;
        end
        out_ready = 1'($urandom_range(0, 1));
        @(negedge clock);
        if (stalled) begin
          chk("stall_valid", a_out_valid, 1);
          chk("stall_data", a_out_data, held_d);
          chk("stall_chan", a_out_chan, held_c);
        end
        if (a_out_valid && out_ready) begin
          chk("str_data", a_out_data, longint'(str_din(rcv)) * 1024);
          chk("str_chan", a_out_chan, rcv % 4);
          rcv++;
          stalled = 1'b0;
        end else if (a_out_valid) begin
          stalled = 1'b1;
          held_d  = a_out_data;
          held_c  = a_out_chan;
        end else begin
          stalled = 1'b0;
        end
        if (in_valid && a_in_ready) sent++;
        tick();
      end
      chk("str_count", rcv, 100);
      in_valid = 1'b0;
      out_ready = 1'b1;
      repeat (3) tick();
      chk("str_no_dup", a_out_valid, 0);
    end

    // Overflow on 16-bit output: 40 * 1024 = 40960.
    c_in_valid = 1'b1; c_in_data = 32'sd40;
    tick();
    c_in_valid = 1'b0;
    tick();
    chk("c_valid", c_out_valid, 1);
    chk("c_data", c_out_data, EXP_C);
    chk("c_ovf_one", c_ovf_count, 1);
    c_ovf_clear = 1'b1;
    tick();
    c_ovf_clear = 1'b0;
    chk("c_ovf_clear", c_ovf_count, 0);

    // Drive the counter up to its saturation point.
    for (int i = 0; i < 65534; i++) begin
      c_in_valid = 1'b1; c_in_data = 32'sd40;
      tick();
    end
    c_in_valid = 1'b0;
    repeat (3) tick();
    chk("c_ovf_fffe", c_ovf_count, 65534);
    for (int k = 0; k < 2; k++) begin
      c_in_valid = 1'b1;
      tick();
      c_in_valid = 1'b0;
      repeat (3) tick();
      chk("c_ovf_sat", c_ovf_count, 65535);
    end

    // Clear coincident with a stage-2 overflow load.
    c_in_valid = 1'b1;
    tick();
    c_in_valid = 1'b0;
    c_ovf_clear = 1'b1;
    tick();
    c_ovf_clear = 1'b0;
    chk("c_clr_coinc", c_ovf_count, 1);
    tick();
    chk("c_clr_hold", c_ovf_count, 1);

    // Reset with two samples in flight.
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = 32'sd7; in_chan = 2'd1;
    tick();
    in_data = 32'sd9; in_chan = 2'd2;
    tick();
    chk("inflight_valid", a_out_valid, 1);
    in_valid = 1'b0;
    reset = 1'b0;
    tick();
    chk("mid_rst_valid", a_out_valid, 0);
    chk("mid_rst_data", a_out_data, 0);
    chk("mid_rst_ovf", a_ovf_count, 0);
    reset = 1'b1;
    chk("post_rst_ready", a_in_ready, 1);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("post_rst_stale", a_out_valid, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/requantize_stream.md
REQUANTIZE_STREAM -- requirements
Module: requantize_stream

Interface
REQ-001 The block SHALL have parameter IN_W, default 32, meaning input sample width (signed two's complement).
REQ-002 The block SHALL have parameter IN_FRAC, default 10, meaning input fractional bits.
REQ-003 The block SHALL have parameter OUT_W, default 32, meaning output sample width (signed).
REQ-004 The block SHALL have parameter OUT_FRAC, default 10, meaning output fractional bits.
REQ-005 The block SHALL have parameter CH_W, default 2, meaning channel-tag width, giving up to 2^CH_W interleaved channels.
REQ-006 The block SHALL have port clock, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-007 The block SHALL have port reset, input, 1 bit, a synchronous active-low reset.
REQ-008 The block SHALL have the following input-side ports:
- in_valid, input, 1 bit: input sample present.
- in_ready, output, 1 bit: block accepts the input sample.
- in_data, input, IN_W bits: input sample.
- in_chan, input, CH_W bits: channel tag.
REQ-009 The block SHALL have the following output-side ports:
- out_valid, output, 1 bit: output sample present.
- out_ready, input, 1 bit: downstream accepts the output sample.
- out_data, output, OUT_W bits: requantized sample.
- out_chan, output, CH_W bits: channel tag, passed through.
REQ-010 The block SHALL have the following control and status ports:
- rnd_mode, input, 2 bits: rounding mode.
- ovf_count, output, 16 bits: overflow event counter.
- ovf_clear, input, 1 bit: clears ovf_count.

Function
REQ-011 The block SHALL compute S = OUT_FRAC - IN_FRAC at elaboration time; all arithmetic SHALL be signed.
REQ-012 For S >= 0 the block SHALL form in_data * 2^S exactly, in a width of IN_W+S.
REQ-013 For S < 0 the block SHALL divide by 2^-S using rnd_mode:
- 0: truncate toward zero (signed-division semantics).
- 1: floor (arithmetic shift).
- 2: round half away from zero.
- 3: behaves as 0.
REQ-014 The block SHALL sample rnd_mode with each accepted input and SHALL carry it with that sample through the pipe.
REQ-015 The block SHALL be a 2-stage pipeline:
- Stage 1: scale and round into an internal wide register.
- Stage 2: narrow to OUT_W and register out_data and out_chan.
REQ-016 Latency SHALL be exactly 2 cycles from the accept edge (in_valid && in_ready) to out_valid with no backpressure.
REQ-017 Throughput SHALL be 1 sample/cycle while out_ready=1.
REQ-018 Each stage SHALL load when it is empty or its contents are leaving that cycle.
REQ-019 in_ready SHALL be !s1_valid || (stage 1 advances); in_ready SHALL be asserted combinationally only from registered state and out_ready.
REQ-020 While out_valid=1 and out_ready=0, out_data and out_chan SHALL hold stable.
REQ-021 No samples SHALL be dropped or duplicated; ordering and channel tags SHALL be preserved.
REQ-022 An overflow event SHALL be a stage-2 load whose wide value lies outside [-2^(OUT_W-1), 2^(OUT_W-1)-1].
REQ-023 ovf_count SHALL increment by 1 per overflow event and SHALL saturate at 0xFFFF.
REQ-024 ovf_clear SHALL zero ovf_count; if an overflow event occurs in the same cycle as ovf_clear, the next value SHALL be 1.
REQ-025 The block SHALL be insensitive to in_data and in_chan while in_valid=0.

Reset
REQ-026 While reset=0 at a clock edge, the block SHALL clear both stage valids, out_valid, out_data and out_chan to 0, and ovf_count to 0.
REQ-027 Reset asserted mid-stream SHALL discard all in-flight samples.
REQ-028 in_ready SHALL be 1 on the first cycle after reset deasserts.

Configuration
REQ-029 The macro SHALL be named REQUANT_SAT_EN.
REQ-030 With REQUANT_SAT_EN defined, out-of-range values SHALL clamp to the OUT_W signed maximum or minimum.
REQ-031 Without REQUANT_SAT_EN, out-of-range values SHALL wrap, keeping the low OUT_W bits.
REQ-032 ovf_count SHALL count overflow events in both builds.

Structure
REQ-033 A shared package SHALL hold:
- the rnd_mode enum (RND_TRUNC=0, RND_FLOOR=1, RND_HALF_AWAY=2);
- the ovf_count width constant (16);
- the default fractional-bit constant (10).
REQ-034 The rounding datapath SHALL be one sub-module, requant_round, which is purely combinational, parametrised by width and S, and instantiated in stage 1.

Verification
REQ-035 IN_FRAC=0, OUT_FRAC=10, input 3 -> output 3072; input -5 -> -5120; out_valid exactly 2 cycles after accept.
REQ-036 IN_FRAC=10, OUT_FRAC=0, input -1536 -> output -1 (mode 0), -2 (mode 1), -2 (mode 2); input 1536 -> 1, 1, 2 respectively.
REQ-037 OUT_W=16, S=+10, input 40 -> 32767 with REQUANT_SAT_EN, -24576 without; ovf_count=1 in both builds.
REQ-038 Stream 100 samples with random out_ready (50%) and tags cycling 0..3 -> outputs in order, tags matched, out_data stable while stalled, no loss or duplication.
REQ-039 ovf_count preset to 0xFFFF then another overflow -> stays 0xFFFF; ovf_clear coincident with overflow -> 1.
REQ-040 Reset=0 with 2 samples in flight -> out_valid=0 next cycle, no stale output after release, in_ready=1.
